// File: rtl/dblbuf_stream_seq.sv
// dblbuf_stream_seq
//   Drives the write port, read port and swap request of a two-bank
//   double-buffer controller. Words arriving on the input stream fill the
//   write bank. The read bank is drained in address order into a 2-entry
//   output FIFO, which feeds the output stream. The banks swap once per frame
//   of DEPTH words, so one frame buffers while the previous one streams out.
//
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   i_in_valid / o_in_ready   input stream handshake, i_in_data word
//   o_out_valid / i_out_ready output stream handshake, o_out_data word,
//                             o_out_last marks word DEPTH-1 of a frame
//   o_swap_n                  one-cycle active-low bank swap request
//   o_w_en_n/o_w_addr/o_w_data  controller write port (write bank)
//   o_r_en_n/o_r_addr         controller read port (read bank)
//   i_r_data                  read data, valid the cycle after o_r_en_n low
//
// This block has no FSM. Its state is a set of counters and flags, and the
// output FIFO.
module dblbuf_stream_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 64
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [DATA_WIDTH-1:0] i_in_data,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_out_last,
   output logic                  o_swap_n,
   output logic                  o_w_en_n,
   output logic [ADDR_WIDTH-1:0] o_w_addr,
   output logic [DATA_WIDTH-1:0] o_w_data,
   output logic                  o_r_en_n,
   output logic [ADDR_WIDTH-1:0] o_r_addr,
   input  logic [DATA_WIDTH-1:0] i_r_data
);

   // Counters need one extra bit so that they can hold the value DEPTH.
   localparam int             CW      = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]  LAST_C  = CW'(DEPTH - 1);

   logic [CW-1:0]         r_fill_cnt;
   logic [CW-1:0]         r_rd_cnt;
   logic                  r_frame_vld;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic [DATA_WIDTH-1:0] r_fifo_data [2];
   logic [1:0]            r_fifo_last;
   logic                  r_fifo_wptr;
   logic                  r_fifo_rptr;
   logic [1:0]            r_fifo_occ;

   logic w_in_ready;
   logic w_in_accept;
   logic w_out_valid;
   logic w_pop;
   logic w_push;
   logic w_credit_ok;
   logic w_issue;
   logic w_swap;

   assign w_in_ready  = (r_fill_cnt != DEPTH_C);
   assign w_in_accept = i_in_valid & w_in_ready;

   assign w_out_valid = (r_fifo_occ != 2'd0);
   assign w_pop       = w_out_valid & i_out_ready;
   assign w_push      = r_inflight;

   // A read may be issued only if there will be a FIFO slot for it.
   // FIFO entries and the read in flight both count against the 2 slots.
   // A pop in this cycle frees one slot. This keeps 1 word/cycle when the
   // output never stalls.
   assign w_credit_ok = ({1'b0, r_fifo_occ} + {2'b00, r_inflight})
                        < (3'd2 + {2'b00, w_pop});
   assign w_issue     = r_frame_vld & (r_rd_cnt != DEPTH_C) & w_credit_ok;

   // The write bank is full. The swap waits until the read bank is free:
   // either it never held a frame, or it is fully drained with no read still
   // waiting for data.
   assign w_swap = (r_fill_cnt == DEPTH_C)
                   & (~r_frame_vld | ((r_rd_cnt == DEPTH_C) & ~r_inflight));

   assign o_in_ready  = w_in_ready;
   assign o_w_en_n    = ~w_in_accept;
   assign o_w_addr    = r_fill_cnt[ADDR_WIDTH-1:0];
   assign o_w_data    = i_in_data;
   assign o_r_en_n    = ~w_issue;
   assign o_r_addr    = r_rd_cnt[ADDR_WIDTH-1:0];
   assign o_swap_n    = ~w_swap;
   assign o_out_valid = w_out_valid;
   assign o_out_data  = r_fifo_data[r_fifo_rptr];
   assign o_out_last  = r_fifo_last[r_fifo_rptr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_fill_cnt      <= '0;
         r_rd_cnt        <= '0;
         r_frame_vld     <= 1'b0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_fifo_data[0]  <= '0;
         r_fifo_data[1]  <= '0;
         r_fifo_last     <= 2'b00;
         r_fifo_wptr     <= 1'b0;
         r_fifo_rptr     <= 1'b0;
         r_fifo_occ      <= 2'd0;
      end else begin
         if (w_swap)
            r_fill_cnt <= '0;
         else if (w_in_accept)
            r_fill_cnt <= r_fill_cnt + CW'(1);

         if (w_swap) begin
            r_rd_cnt    <= '0;
            r_frame_vld <= 1'b1;
         end else if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + CW'(1);
         end

         r_inflight      <= w_issue;
         r_inflight_last <= w_issue & (r_rd_cnt == LAST_C);

         if (w_push) begin
            r_fifo_data[r_fifo_wptr] <= i_r_data;
            r_fifo_last[r_fifo_wptr] <= r_inflight_last;
            r_fifo_wptr              <= ~r_fifo_wptr;
         end
         if (w_pop)
            r_fifo_rptr <= ~r_fifo_rptr;

         case ({w_push, w_pop})
            2'b10:   r_fifo_occ <= r_fifo_occ + 2'd1;
            2'b01:   r_fifo_occ <= r_fifo_occ - 2'd1;
            default: r_fifo_occ <= r_fifo_occ;
         endcase
      end
   end

endmodule

// File: tb/tb_dblbuf_stream_seq.sv
// tb_dblbuf_stream_seq
//   Bench for dblbuf_stream_seq, with DEPTH=4. A behavioural two-bank
//   controller model sits between the write port and the read port. Words sent
//   on the input stream are pushed into a scoreboard queue with their expected
//   last flag. A monitor pops the queue on every output handshake and compares.
module tb_dblbuf_stream_seq;

   localparam int DW    = 16;
   localparam int AW    = 6;
   localparam int DEPTH = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          swap_n;
   logic          w_en_n;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic          r_en_n;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data = '0;

   always #5 clock = ~clock;

   dblbuf_stream_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_last  (out_last),
      .o_swap_n    (swap_n),
      .o_w_en_n    (w_en_n),
      .o_w_addr    (w_addr),
      .o_w_data    (w_data),
      .o_r_en_n    (r_en_n),
      .o_r_addr    (r_addr),
      .i_r_data    (r_data)
   );

   // Double-buffer controller: writes go to the write bank, reads come from
   // the other bank one cycle later, and a swap exchanges the two banks.
   logic [DW-1:0] bank [2][2**AW];
   logic          wbank = 1'b0;
   always @(posedge clock) begin
      if (!w_en_n) bank[wbank][w_addr] <= w_data;
      if (!r_en_n) r_data <= bank[~wbank][r_addr];
      if (!swap_n) wbank <= ~wbank;
   end

   int total = 0;
   int bad   = 0;
   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, req, $time);
      end
   endfunction

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] tx_q[$];
   int            swap_cyc[$];
   int            acc_cnt = 0, rd_total = 0, n_pop = 0, n_swap = 0, occ_m = 0, cyc = 0;
   bit            prev_rd = 0, prev_pop_nl = 0, gap_en = 0, in_rand = 0;
   int            out_mode = 1, pop_limit = 0;

   // Monitor: samples the DUT at the falling edge. The handshakes it sees
   // take effect at the next rising edge.
   always @(negedge clock) begin : mon
      logic hs, pp, rd, wr, sw;
      int   nxt;
      exp_t e;
      cyc++;
      if (!reset_n) begin
         exp_q.delete();
         acc_cnt = 0; rd_total = 0; n_pop = 0; occ_m = 0;
         prev_rd = 0; prev_pop_nl = 0;
      end else begin
         hs = in_valid & in_ready;
         pp = out_valid & out_ready;
         rd = ~r_en_n;
         wr = ~w_en_n;
         sw = ~swap_n;
         chk("wen", {31'd0, w_en_n}, {31'd0, ~hs});
         if (hs) begin
            chk("waddr", 32'(w_addr), 32'(acc_cnt % DEPTH));
            e.d = in_data;
            e.l = ((acc_cnt % DEPTH) == DEPTH - 1);
            exp_q.push_back(e);
            acc_cnt++;
         end
         if (rd) begin
            chk("raddr", 32'(r_addr), 32'(rd_total % DEPTH));
            rd_total++;
         end
         if (gap_en && prev_pop_nl && out_ready) chk("gap", {31'd0, out_valid}, 32'd1);
         if (pp) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("odata", 32'(out_data), 32'(e.d));
               chk("olast", {31'd0, out_last}, {31'd0, e.l});
            end
            n_pop++;
         end
         if (sw) begin
            chk("swap_with_write", {31'd0, wr}, 32'd0);
            chk("swap_with_read", {31'd0, rd}, 32'd0);
            chk("swap_with_inflight", {31'd0, prev_rd}, 32'd0);
            swap_cyc.push_back(cyc);
            n_swap++;
         end
         // Output FIFO occupancy, derived from reads (one cycle later) and pops.
         chk("ovalid", {31'd0, out_valid}, {31'd0, occ_m != 0});
         nxt = occ_m + int'(prev_rd) - int'(pp);
         chk("fifo_overflow", {31'd0, nxt <= 2}, 32'd1);
         occ_m = nxt;
         prev_rd = rd;
         prev_pop_nl = pp & ~out_last;
      end
   end

   // Input driver: sends tx_q in order. Once valid is raised, it is held
   // until the word is accepted.
   initial begin : in_drv
      logic hs;
      in_valid = 1'b0;
      in_data  = '0;
      forever begin
         @(negedge clock);
         hs = in_valid & in_ready & reset_n;
         @(posedge clock);
         #1;
         if (hs) void'(tx_q.pop_front());
         if (!(in_valid && !hs)) begin
            if (tx_q.size() > 0 && (!in_rand || $urandom_range(0, 3) != 0)) begin
               in_valid = 1'b1;
               in_data  = tx_q[0];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
   end

   // Output ready driver: 0 = low, 1 = high, 2 = random, 3 = high until
   // pop_limit pops have been seen.
   initial begin : out_drv
      out_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (out_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (n_pop < pop_limit);
         endcase
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_idle(input int maxc);
      int c = 0;
      while ((tx_q.size() != 0 || exp_q.size() != 0 || in_valid) && c < maxc) begin
         tick();
         c++;
      end
      chk("drain", 32'(tx_q.size() + exp_q.size()), 32'd0);
   endtask

   initial begin : timeout
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      bit found, prev_w4;
      int lat, s0, s1, bp;
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b1;

      // 1: idle after reset
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
         chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
         chk("t1_swap_n", {31'd0, swap_n}, 32'd1);
         chk("t1_w_en_n", {31'd0, w_en_n}, 32'd1);
         chk("t1_r_en_n", {31'd0, r_en_n}, 32'd1);
      end

      // 2: one frame A0..A3
      for (int i = 0; i < 4; i++) tx_q.push_back(DW'(32'hA0 + i));
      found = 0; prev_w4 = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick();
         if (!swap_n) found = 1;
         else prev_w4 = !w_en_n && (w_addr == AW'(3));
      end
      chk("t2_swap_seen", {31'd0, found}, 32'd1);
      chk("t2_swap_after_4th_write", {31'd0, prev_w4}, 32'd1);
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         tick();
         if (!r_en_n) found = 1;
      end
      chk("t2_first_read", {31'd0, found}, 32'd1);
      found = 0; lat = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         tick();
         lat++;
         if (out_valid) found = 1;
      end
      chk("t2_read_to_valid", 32'(lat), 32'd2);
      wait_idle(200);

      // 3: three frames, continuous input and output. With continuous input a
      // frame fills in DEPTH cycles right after the previous swap. The swap
      // then waits one more cycle for the last read's data, so swaps are
      // DEPTH+2 cycles apart.
      s0 = swap_cyc.size();
      gap_en = 1;
      for (int i = 0; i < 12; i++) tx_q.push_back(DW'(32'h300 + i));
      wait_idle(400);
      gap_en = 0;
      chk("t3_swaps", 32'(swap_cyc.size() - s0), 32'd3);
      if (swap_cyc.size() - s0 >= 3)
         for (int k = 1; k < 3; k++)
            chk("t3_swap_period", 32'(swap_cyc[s0+k] - swap_cyc[s0+k-1]), 32'(DEPTH + 2));

      // 4: output stalled for 20 cycles after the first word of a frame
      s0 = n_swap;
      bp = n_pop;
      for (int i = 0; i < 4; i++) tx_q.push_back(DW'(32'h400 + i));
      for (int i = 0; i < 4; i++) tx_q.push_back(DW'(32'h410 + i));
      for (int c = 0; c < 100 && n_pop == bp; c++) tick();
      out_mode = 0;
      repeat (20) tick();
      chk("t4_fifo_holds_2", 32'(rd_total - n_pop), 32'd2);
      chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_r_en_n", {31'd0, r_en_n}, 32'd1);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_swap_n", {31'd0, swap_n}, 32'd1);
      chk("t4_swaps_during_stall", 32'(n_swap - s0), 32'd1);
      out_mode = 1;
      wait_idle(200);
      chk("t4_swap_after_release", 32'(n_swap - s0), 32'd2);

      // 5: reset after 2 writes of the next frame and 1 pop
      out_mode = 0;
      s0 = n_swap;
      for (int i = 0; i < 4; i++) tx_q.push_back(DW'(32'h500 + i));
      for (int c = 0; c < 40 && n_swap == s0; c++) tick();
      repeat (6) tick();
      tx_q.push_back(DW'(32'h510));
      tx_q.push_back(DW'(32'h511));
      for (int c = 0; c < 20 && (tx_q.size() != 0 || in_valid); c++) tick();
      chk("t5_fifo_full", 32'(rd_total - n_pop), 32'd2);
      pop_limit = n_pop + 1;
      out_mode = 3;
      for (int c = 0; c < 20 && n_pop < pop_limit; c++) tick();
      out_mode = 0;
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t5_rst_swap_n", {31'd0, swap_n}, 32'd1);
      chk("t5_rst_w_en_n", {31'd0, w_en_n}, 32'd1);
      chk("t5_rst_r_en_n", {31'd0, r_en_n}, 32'd1);
      @(posedge clock);
      #2 reset_n = 1'b1;
      s1 = n_swap;
      out_mode = 1;
      for (int i = 0; i < 4; i++) tx_q.push_back(DW'(32'hB0 + i));
      wait_idle(200);
      chk("t5_frame_after_reset_swaps", 32'(n_swap - s1), 32'd1);

      // 6: random valid/ready, 50 frames
      in_rand = 1;
      out_mode = 2;
      bp = n_pop;
      for (int i = 0; i < 50 * DEPTH; i++) tx_q.push_back(DW'($urandom));
      wait_idle(20000);
      chk("t6_words_out", 32'(n_pop - bp), 32'(50 * DEPTH));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
